// File: rtl/multicycle_alu_if.sv
// Handshake and operand/result bundle between the EX-stage control and the
// multicycle ALU. The master issues operations; the slave (the ALU) answers.
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       opt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             div_zero;

    modport master (
        output start, opt, a, b,
        input  busy, done, out, hi, zero, negative, overflow, div_zero
    );

    modport slave (
        input  start, opt, a, b,
        output busy, done, out, hi, zero, negative, overflow, div_zero
    );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative (1 bit/cycle)
// signed/unsigned multiply and restoring divide, with start/busy/done handshake.
// Multiply and divide run on operand magnitudes; signs are fixed up when the
// result is registered on the edge that enters DONE.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    multicycle_alu_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_MULU = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_DIVU = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_SLL  = 4'd10;
    localparam logic [3:0] OP_SRL  = 4'd11;
    localparam logic [3:0] OP_SRA  = 4'd12;
    localparam logic [3:0] OP_SLT  = 4'd13;
    localparam logic [3:0] OP_SLTU = 4'd14;

    typedef enum logic [1:0] {IDLE, SINGLE, ITER, DONE} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         op_reg;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [WIDTH-1:0]   mcand_reg;        // multiplicand (MUL) or divisor (DIV) magnitude
    logic [2*WIDTH-1:0] acc_reg;          // {hi, lo} product or {remainder, quotient}
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   out_reg, hi_reg;
    logic               zero_reg, negative_reg, overflow_reg, div_zero_reg;

    logic               busy, done;
    logic               accept, finish;
    logic               in_mul, in_div, in_signed, in_iter;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in;
    state_t             start_target;

    logic               is_mul;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] acc_step;

    logic [WIDTH-1:0]   add_res, sub_res;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   res_out, res_hi;
    logic               res_ovf, res_dz, res_flags_en;

    // Accept decode and operand magnitudes for the iterative engines.
    always_comb begin
        accept    = bus.start && (state_reg == IDLE || state_reg == DONE);
        in_mul    = (bus.opt == OP_MUL) || (bus.opt == OP_MULU);
        in_div    = (bus.opt == OP_DIV) || (bus.opt == OP_DIVU);
        in_signed = (bus.opt == OP_MUL) || (bus.opt == OP_DIV);
        in_iter   = in_mul || (in_div && (bus.b != '0));
        a_mag_in  = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag_in  = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        start_target = in_iter ? ITER : SINGLE;
        finish    = (state_reg == SINGLE) ||
                    (state_reg == ITER && cnt_reg == CW'(WIDTH));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) state_next = start_target;
            end
            SINGLE: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            ITER: begin
                busy = 1'b1;
                if (cnt_reg == CW'(WIDTH)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = bus.start ? start_target : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        is_mul    = (op_reg == OP_MUL) || (op_reg == OP_MULU);
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                    (acc_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
        div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, mcand_reg};
        if (is_mul)
            acc_step = {mul_sum, acc_reg[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            acc_step = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        else
            acc_step = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end

    // Result selection and flag generation for the operation being finished.
    always_comb begin
        add_res  = a_reg + b_reg;
        sub_res  = a_reg - b_reg;
        prod_fix = (op_reg == OP_MUL && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]))
                   ? -acc_reg : acc_reg;
        quo_fix  = (op_reg == OP_DIV && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]))
                   ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem_fix  = (op_reg == OP_DIV && a_reg[WIDTH-1])
                   ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
        res_out      = '0;
        res_hi       = '0;
        res_ovf      = 1'b0;
        res_dz       = 1'b0;
        res_flags_en = 1'b1;
        case (op_reg)
            OP_ADD: begin
                res_out = add_res;
                res_ovf = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                          (add_res[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                res_out = sub_res;
                res_ovf = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                          (sub_res[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_MUL, OP_MULU: begin
                res_out = prod_fix[WIDTH-1:0];
                res_hi  = prod_fix[2*WIDTH-1:WIDTH];
            end
            OP_DIV, OP_DIVU: begin
                if (b_reg == '0) begin
                    res_out = '1;
                    res_hi  = a_reg;
                    res_dz  = 1'b1;
                end else begin
                    res_out = quo_fix;
                    res_hi  = rem_fix;
                    // MIN / -1: the magnitude path already yields MIN, rem 0.
                    res_ovf = (op_reg == OP_DIV) &&
                              (a_reg == {1'b1, {(WIDTH-1){1'b0}}}) &&
                              (b_reg == '1);
                end
            end
            OP_XOR:  res_out = a_reg ^ b_reg;
            OP_AND:  res_out = a_reg & b_reg;
            OP_OR:   res_out = a_reg | b_reg;
            OP_NOR:  res_out = ~(a_reg | b_reg);
            OP_SLL:  res_out = a_reg << b_reg[SHW-1:0];
            OP_SRL:  res_out = a_reg >> b_reg[SHW-1:0];
            OP_SRA:  res_out = $signed(a_reg) >>> b_reg[SHW-1:0];
            OP_SLT:  res_out = {{(WIDTH-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
            OP_SLTU: res_out = {{(WIDTH-1){1'b0}}, (a_reg < b_reg)};
            default: res_flags_en = 1'b0;
        endcase
    end

    // Operand capture, iteration, and result registers loaded on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            mcand_reg    <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            out_reg      <= '0;
            hi_reg       <= '0;
            zero_reg     <= 1'b0;
            negative_reg <= 1'b0;
            overflow_reg <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            if (accept) begin
                op_reg  <= bus.opt;
                a_reg   <= bus.a;
                b_reg   <= bus.b;
                cnt_reg <= '0;
                if (in_mul) begin
                    acc_reg   <= {{WIDTH{1'b0}}, b_mag_in};
                    mcand_reg <= a_mag_in;
                end else begin
                    acc_reg   <= {{WIDTH{1'b0}}, a_mag_in};
                    mcand_reg <= b_mag_in;
                end
            end else if (state_reg == ITER && cnt_reg != CW'(WIDTH)) begin
                acc_reg <= acc_step;
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (finish) begin
                out_reg      <= res_out;
                hi_reg       <= res_hi;
                zero_reg     <= res_flags_en && (res_out == '0);
                negative_reg <= res_flags_en && res_out[WIDTH-1];
                overflow_reg <= res_ovf;
                div_zero_reg <= res_dz;
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.out      = out_reg;
    assign bus.hi       = hi_reg;
    assign bus.zero     = zero_reg;
    assign bus.negative = negative_reg;
    assign bus.overflow = overflow_reg;
    assign bus.div_zero = div_zero_reg;
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH=32): each issued operation pushes
// a reference result and due cycle; a monitor pops and compares on done.
module tb_multicycle_alu;
    localparam int W = 32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic [31:0] hi;
        logic [3:0]  flags;   // {zero, negative, overflow, div_zero}
        int          lat;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks_cnt = 0;
    int   errors_cnt = 0;
    exp_t sb_q[$];
    logic [31:0] last_out = '0;
    logic [31:0] last_hi  = '0;

    multicycle_alu_if #(.WIDTH(W)) bus ();

    multicycle_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model computed with wide integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint sx, sy, s;
        logic [63:0] p;
        logic [31:0] o, h;
        logic ov, dz, fl;
        int sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        s = 0; p = '0; o = '0; h = '0; ov = 1'b0; dz = 1'b0; fl = 1'b1;
        sh = int'(y[4:0]);
        e.lat = 1;
        case (op)
            4'd0: begin s = sx + sy; o = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
            4'd1: begin s = sx - sy; o = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
            4'd2: begin p = sx * sy; o = p[31:0]; h = p[63:32]; e.lat = W + 1; end
            4'd3: begin p = {32'd0, x} * {32'd0, y}; o = p[31:0]; h = p[63:32]; e.lat = W + 1; end
            4'd4: begin
                if (y == 0) begin o = '1; h = x; dz = 1'b1; end
                else begin
                    e.lat = W + 1;
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin o = x; h = '0; ov = 1'b1; end
                    else begin o = 32'(sx / sy); h = 32'(sx % sy); end
                end
            end
            4'd5: begin
                if (y == 0) begin o = '1; h = x; dz = 1'b1; end
                else begin e.lat = W + 1; o = x / y; h = x % y; end
            end
            4'd6:  o = x ^ y;
            4'd7:  o = x & y;
            4'd8:  o = x | y;
            4'd9:  o = ~(x | y);
            4'd10: o = x << sh;
            4'd11: o = x >> sh;
            4'd12: o = 32'($signed(x) >>> sh);
            4'd13: o = (sx < sy) ? 32'd1 : 32'd0;
            4'd14: o = (x < y) ? 32'd1 : 32'd0;
            default: fl = 1'b0;
        endcase
        e.op = op; e.a = x; e.b = y; e.out = o; e.hi = h;
        e.flags = {fl && (o == 0), fl && o[31], ov, dz};
        e.due = 0;
        return e;
    endfunction

    // Issue one operation; called at a falling edge, returns at the falling
    // edge after the accepting rising edge with start released.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int g;
        g = 0;
        while (bus.busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check_val("idle_timeout", 64'(g), 64'd0);
        e = model(op, x, y);
        bus.start = 1'b1; bus.opt = op; bus.a = x; bus.b = y;
        @(posedge clk);
        #1;
        e.due = cyc + e.lat;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                $display("txn op=%0d a=%h b=%h out=%h hi=%h flags=%b cyc=%0d",
                         e.op, e.a, e.b, bus.out, bus.hi,
                         {bus.zero, bus.negative, bus.overflow, bus.div_zero}, cyc);
                check_val($sformatf("latency_op%0d", e.op), 64'(cyc), 64'(e.due));
                check_val($sformatf("out_op%0d", e.op), 64'(bus.out), 64'(e.out));
                check_val($sformatf("hi_op%0d", e.op), 64'(bus.hi), 64'(e.hi));
                check_val($sformatf("flags_op%0d", e.op),
                          64'({bus.zero, bus.negative, bus.overflow, bus.div_zero}), 64'(e.flags));
                check_val("busy_at_done", 64'(bus.busy), 64'd0);
                last_out = e.out;
                last_hi  = e.hi;
            end
        end
    end

    initial begin
        int g;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1;
        bus.start = 1'b0; bus.opt = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        check_val("reset_busy", 64'(bus.busy), 64'd0);
        check_val("reset_done", 64'(bus.done), 64'd0);
        check_val("reset_out", 64'(bus.out), 64'd0);
        check_val("reset_hi", 64'(bus.hi), 64'd0);
        check_val("reset_flags", 64'({bus.zero, bus.negative, bus.overflow, bus.div_zero}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases, issued back to back (each accepted in the DONE cycle).
        issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        issue(4'd2, 32'hFFFF_FFFD, 32'd7);
        issue(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(4'd4, 32'hFFFF_FFF9, 32'd2);
        issue(4'd5, 32'd100, 32'd7);
        issue(4'd4, 32'd5, 32'd0);
        issue(4'd5, 32'd9, 32'd0);
        issue(4'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'd1, 32'h8000_0000, 32'd1);
        issue(4'd10, 32'd1, 32'h0000_0021);
        issue(4'd12, 32'h8000_0000, 32'd4);
        issue(4'd11, 32'h8000_0000, 32'hFFFF_FFE4);
        issue(4'd13, 32'hFFFF_FFFF, 32'd1);
        issue(4'd14, 32'hFFFF_FFFF, 32'd1);
        issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);

        // start held high during a multiply: ignored, outputs held.
        issue(4'd2, 32'd12345, 32'hFFFF_FD4A);
        for (int i = 0; i < 20; i++) begin
            bus.start = 1'b1; bus.opt = 4'd0; bus.a = $urandom; bus.b = $urandom;
            @(negedge clk);
            check_val("hold_busy", 64'(bus.busy), 64'd1);
            check_val("hold_out", 64'(bus.out), 64'(last_out));
            check_val("hold_hi", 64'(bus.hi), 64'(last_hi));
        end
        bus.start = 1'b0;

        // Random operations with occasional boundary operands.
        for (int i = 0; i < 30; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 1) rb = 32'd0;
            if (i % 7 == 2) ra = 32'h8000_0000;
            if (i % 6 == 3) rb = 32'hFFFF_FFFF;
            issue(rop, ra, rb);
        end

        // Reset in the middle of a divide aborts it silently.
        issue(4'd6, 32'd1, 32'd0);
        issue(4'd5, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("abort_busy", 64'(bus.busy), 64'd0);
        check_val("abort_done", 64'(bus.done), 64'd0);
        check_val("abort_out", 64'(bus.out), 64'd0);
        check_val("abort_hi", 64'(bus.hi), 64'd0);
        void'(sb_q.pop_back());
        reset = 1'b0;
        repeat (45) @(negedge clk);
        check_val("abort_no_done_pending", 64'(sb_q.size()), 64'd0);

        issue(4'd0, 32'd2, 32'd3);
        issue(4'd3, 32'd6, 32'd7);

        g = 0;
        while (sb_q.size() > 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check_val("drain_queue", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
